// File: rtl/rsm_datapath_seq.sv
// Self-sequencing register/shift/ALU datapath: one op per handshake, stepped
// through register read, shift+ALU execute and writeback.
module rsm_datapath_seq #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_alu,
  input  logic [1:0]       op_shift,
  input  logic             op_asel,
  input  logic             op_bsel,
  input  logic             op_wr,
  input  logic [AW-1:0]    op_rn,
  input  logic [AW-1:0]    op_rm,
  input  logic [AW-1:0]    op_rd,
  input  logic [WIDTH-1:0] op_imm,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  input  logic [AW-1:0]    dbg_rnum,
  output logic [WIDTH-1:0] dbg_rdata
);

  // state | meaning
  // IDLE  | waiting for an op, op_ready high
  // RDA   | A <= R[rn]
  // RDB   | B <= R[rm]
  // EXEC  | result/status <= ALU(Ain, Bin)
  // WB    | optional R[rd] <= result, done pulse
  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

  state_t state_q, state_d;

  logic [1:0]       alu_q, shift_q;
  logic             asel_q, bsel_q, wr_q;
  logic [AW-1:0]    rn_q, rm_q, rd_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       status_q;
  logic [WIDTH-1:0] rf_q [NREGS];

  logic [WIDTH-1:0] a_in, b_sh, b_in, alu_res;
  logic             ovf;

  always_comb begin
    state_d  = state_q;
    op_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_d = RDA;
      end
      RDA:  state_d = RDB;
      RDB:  state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_in = asel_q ? '0 : a_q;
    case (shift_q)
      2'b01:   b_sh = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[WIDTH-1:1]};
      2'b11:   b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_sh = b_q;
    endcase
    b_in    = bsel_q ? imm_q : b_sh;
    alu_res = '0;
    ovf     = 1'b0;
    case (alu_q)
      2'b00: begin
        alu_res = a_in + b_in;
        ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (alu_res[WIDTH-1] != a_in[WIDTH-1]);
      end
      2'b01: begin
        alu_res = a_in - b_in;
        ovf = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (alu_res[WIDTH-1] != a_in[WIDTH-1]);
      end
      2'b10:   alu_res = a_in & b_in;
      default: alu_res = ~b_in;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      alu_q    <= '0;
      shift_q  <= '0;
      asel_q   <= 1'b0;
      bsel_q   <= 1'b0;
      wr_q     <= 1'b0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (op_valid) begin
          alu_q   <= op_alu;
          shift_q <= op_shift;
          asel_q  <= op_asel;
          bsel_q  <= op_bsel;
          wr_q    <= op_wr;
          rn_q    <= op_rn;
          rm_q    <= op_rm;
          rd_q    <= op_rd;
          imm_q   <= op_imm;
        end
        RDA:  a_q <= rf_q[rn_q];
        RDB:  b_q <= rf_q[rm_q];
        EXEC: begin
          result_q <= alu_res;
          status_q <= {ovf, alu_res[WIDTH-1], (alu_res == '0)};
        end
        default: ;
      endcase
    end
  end

  // Writeback reads result_q, so rd may alias rn/rm without hazard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (state_q == WB && wr_q) begin
      rf_q[rd_q] <= result_q;
    end
  end

  assign result    = result_q;
  assign status    = status_q;
  assign dbg_rdata = rf_q[dbg_rnum];

endmodule
